data_mem_responder: RTL

Memory-side responder for the multicycle CPU data-memory interface. It accepts the control unit's mRD/mWR strobes and serves 32-bit word reads and writes from a byte-organised, big-endian RAM. Access latency is programmable through wait states, and completion is signalled with a one-cycle mReady pulse. It sits between the CPU datapath (ALU result as address, rt as write data) and the DBDataSrc mux.

---
 rtl/data_mem_responder.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder: word reads/writes on a byte-wide big-endian RAM with programmable wait states.
// Build option: define DMEM_ALIGN_CHECK_EN to flag non-word-aligned addresses as errors.
module data_mem_responder #(
    parameter int DEPTH       = 128,
    parameter int AW          = 32,
    parameter int WAIT_CYCLES = 0
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          mRD,
    input  logic          mWR,
    input  logic [AW-1:0] DAddr,
    input  logic [31:0]   DataIn,
    output logic [31:0]   DataOut,
    output logic          mReady,
    output logic          mBusy,
    output logic          mErr
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic          armed_q, armed_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [IW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          isWrite_q, isWrite_d;
    logic          err_q, err_d;
    logic [31:0]   dout_q, dout_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          merr_q, merr_d;

    logic [7:0]    mem [DEPTH];
    logic          memWe;
    logic [IW-1:0] idx0, idx1, idx2, idx3;
    logic [31:0]   rdWord;
    logic [AW:0]   endAddr;
    logic          rangeErr;
    logic          alignErr;

    // The range test is done one bit wider than the address so addresses near the top never wrap into range.
    assign endAddr  = {1'b0, DAddr} + (AW+1)'(3);
    assign rangeErr = (endAddr >= (AW+1)'(DEPTH));

`ifdef DMEM_ALIGN_CHECK_EN
    assign alignErr = (DAddr[1:0] != 2'b00);
`else
    assign alignErr = 1'b0;
`endif

    assign idx0   = addr_q;
    assign idx1   = addr_q + IW'(1);
    assign idx2   = addr_q + IW'(2);
    assign idx3   = addr_q + IW'(3);
    assign rdWord = {mem[idx0], mem[idx1], mem[idx2], mem[idx3]};

    always_comb begin
        state_d   = state_q;
        armed_d   = armed_q | (~mRD & ~mWR);
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        isWrite_d = isWrite_q;
        err_d     = err_q;
        dout_d    = dout_q;
        ready_d   = 1'b0;
        busy_d    = busy_q;
        merr_d    = 1'b0;
        memWe     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (armed_q && (mRD || mWR)) begin
                    addr_d    = DAddr[IW-1:0];
                    wdata_d   = DataIn;
                    isWrite_d = mWR;
                    err_d     = (mRD && mWR) || rangeErr || alignErr;
                    busy_d    = 1'b1;
                    armed_d   = 1'b0;
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                merr_d  = err_q;
                state_d = S_IDLE;
                if (!err_q) begin
                    if (isWrite_q) begin
                        memWe = 1'b1;
                    end else begin
                        dout_d = rdWord;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            armed_q   <= 1'b1;
            cnt_q     <= 4'd0;
            addr_q    <= '0;
            wdata_q   <= 32'd0;
            isWrite_q <= 1'b0;
            err_q     <= 1'b0;
            dout_q    <= 32'd0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            merr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            armed_q   <= armed_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            isWrite_q <= isWrite_d;
            err_q     <= err_d;
            dout_q    <= dout_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            merr_q    <= merr_d;
        end
    end

    // RAM is deliberately outside the reset domain; a reset forces IDLE so no commit can occur.
    always_ff @(posedge CLK) begin
        if (memWe) begin
            mem[idx0] <= wdata_q[31:24];
            mem[idx1] <= wdata_q[23:16];
            mem[idx2] <= wdata_q[15:8];
            mem[idx3] <= wdata_q[7:0];
        end
    end

    assign DataOut = dout_q;
    assign mReady  = ready_q;
    assign mBusy   = busy_q;
    assign mErr    = merr_q;

endmodule
